// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: commit bundle, ROB entry layout and alloc encodings.
package reorder_buffer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_WIDTH  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_data_t;
  typedef logic                  bool_t;

  typedef struct packed {
    logic      write_reg_need;
    reg_addr_t write_reg_addr;
    reg_data_t result;
  } cmt_require_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    logic      reg_need;
    reg_addr_t reg_addr;
    reg_data_t result;
  } rob_entry_t;

  typedef enum logic [1:0] {
    ALLOC_NONE = 2'b00,
    ALLOC_ONE  = 2'b01,
    ALLOC_BAD  = 2'b10,
    ALLOC_TWO  = 2'b11
  } alloc_req_e;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_storage.sv
// ROB entry array: two alloc write ports, two writeback ports, two head read ports with retire clear.
module rob_storage
  import reorder_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int ID_W  = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [1:0]                  alloc_we,
  input  logic [1:0][ID_W-1:0]        alloc_idx,
  input  logic [1:0]                  alloc_need,
  input  logic [1:0][REG_ADDR_W-1:0]  alloc_addr,
  input  logic [1:0]                  wb_valid,
  input  logic [1:0][ID_W-1:0]        wb_id,
  input  logic [1:0][REG_WIDTH-1:0]   wb_result,
  input  logic [1:0]                  ret_clr,
  input  logic [1:0][ID_W-1:0]        rd_idx,
  output rob_entry_t [1:0]            rd_entry
);

  rob_entry_t mem [DEPTH];

  assign rd_entry[0] = mem[rd_idx[0]];
  assign rd_entry[1] = mem[rd_idx[1]];

  // Write order gives port1 priority over port0, and retire clears after writeback.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem <= '{default: '0};
    end else begin
      if (wb_valid[0] && mem[wb_id[0]].valid) begin
        mem[wb_id[0]].done   <= 1'b1;
        mem[wb_id[0]].result <= wb_result[0];
      end
      if (wb_valid[1] && mem[wb_id[1]].valid) begin
        mem[wb_id[1]].done   <= 1'b1;
        mem[wb_id[1]].result <= wb_result[1];
      end
      if (ret_clr[0]) begin
        mem[rd_idx[0]].valid <= 1'b0;
        mem[rd_idx[0]].done  <= 1'b0;
      end
      if (ret_clr[1]) begin
        mem[rd_idx[1]].valid <= 1'b0;
        mem[rd_idx[1]].done  <= 1'b0;
      end
      if (alloc_we[0])
        mem[alloc_idx[0]] <= '{valid: 1'b1, done: 1'b0, reg_need: alloc_need[0],
                               reg_addr: alloc_addr[0], result: '0};
      if (alloc_we[1])
        mem[alloc_idx[1]] <= '{valid: 1'b1, done: 1'b0, reg_need: alloc_need[1],
                               reg_addr: alloc_addr[1], result: '0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(wb_valid[0] && !mem[wb_id[0]].valid));
      assert (!(wb_valid[1] && !mem[wb_id[1]].valid));
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Dual-issue reorder buffer: in-order alloc, out-of-order writeback, in-order dual retire.
// Optional ROB_WB_BYPASS_EN lets a same-cycle writeback to head/head+1 retire immediately.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int ID_W  = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [1:0]                  alloc_req,
  input  logic [1:0]                  alloc_reg_need,
  input  logic [1:0][REG_ADDR_W-1:0]  alloc_reg_addr,
  output logic                        alloc_ready,
  output logic [1:0][ID_W-1:0]        alloc_id,
  input  logic [1:0]                  wb_valid,
  input  logic [1:0][ID_W-1:0]        wb_id,
  input  logic [1:0][REG_WIDTH-1:0]   wb_result,
  output cmt_require_t [1:0]          cmt_require,
  output logic [ID_W:0]               count,
  output logic                        empty
);

  typedef logic [ID_W-1:0] ptr_t;
  typedef logic [ID_W:0]   cnt_t;

  ptr_t                        head;
  ptr_t                        tail;
  logic [1:0][ID_W-1:0]        head_idx;
  rob_entry_t [1:0]            hd;
  logic [1:0]                  hd_done;
  logic [1:0][REG_WIDTH-1:0]   hd_result;
  logic [1:0]                  alloc_we;
  logic [1:0]                  ret;
  cmt_require_t [1:0]          cmt_nxt;

  assign alloc_ready = (count <= cnt_t'(DEPTH - 2));
  assign empty       = (count == '0);
  assign alloc_id[0] = tail;
  assign alloc_id[1] = tail + ptr_t'(1);
  assign head_idx[0] = head;
  assign head_idx[1] = head + ptr_t'(1);

  always_comb begin
    alloc_we = '0;
    if (alloc_ready && !flush) begin
      case (alloc_req_e'(alloc_req))
        ALLOC_ONE: alloc_we = 2'b01;
        ALLOC_TWO: alloc_we = 2'b11;
        default:   alloc_we = '0;
      endcase
    end
  end

  rob_storage #(.DEPTH(DEPTH)) u_storage (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_we   (alloc_we),
    .alloc_idx  (alloc_id),
    .alloc_need (alloc_reg_need),
    .alloc_addr (alloc_reg_addr),
    .wb_valid   (wb_valid),
    .wb_id      (wb_id),
    .wb_result  (wb_result),
    .ret_clr    (ret),
    .rd_idx     (head_idx),
    .rd_entry   (hd)
  );

  always_comb begin
    hd_done      = {hd[1].done, hd[0].done};
    hd_result[0] = hd[0].result;
    hd_result[1] = hd[1].result;
`ifdef ROB_WB_BYPASS_EN
    // Port1 checked last so it wins, matching the storage write order.
    if (wb_valid[0] && wb_id[0] == head_idx[0]) begin
      hd_done[0]   = 1'b1;
      hd_result[0] = wb_result[0];
    end
    if (wb_valid[1] && wb_id[1] == head_idx[0]) begin
      hd_done[0]   = 1'b1;
      hd_result[0] = wb_result[1];
    end
    if (wb_valid[0] && wb_id[0] == head_idx[1]) begin
      hd_done[1]   = 1'b1;
      hd_result[1] = wb_result[0];
    end
    if (wb_valid[1] && wb_id[1] == head_idx[1]) begin
      hd_done[1]   = 1'b1;
      hd_result[1] = wb_result[1];
    end
`endif
  end

  always_comb begin
    ret     = '0;
    cmt_nxt = '0;
    if (!flush) begin
      ret[0] = hd[0].valid && hd_done[0];
      ret[1] = ret[0] && hd[1].valid && hd_done[1];
    end
    if (ret[0]) cmt_nxt[0] = '{write_reg_need: hd[0].reg_need,
                               write_reg_addr: hd[0].reg_addr, result: hd_result[0]};
    if (ret[1]) cmt_nxt[1] = '{write_reg_need: hd[1].reg_need,
                               write_reg_addr: hd[1].reg_addr, result: hd_result[1]};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      cmt_require <= '0;
    end else begin
      head        <= head + ptr_t'(pop2(ret));
      tail        <= tail + ptr_t'(pop2(alloc_we));
      count       <= count + cnt_t'(pop2(alloc_we)) - cnt_t'(pop2(ret));
      cmt_require <= cmt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (alloc_req != ALLOC_BAD);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer in its default (non-bypass) build.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int ID_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst, flush;
  logic [1:0]               alloc_req, alloc_reg_need;
  logic [1:0][4:0]          alloc_reg_addr;
  logic                     alloc_ready;
  logic [1:0][ID_W-1:0]     alloc_id;
  logic [1:0]               wb_valid;
  logic [1:0][ID_W-1:0]     wb_id;
  logic [1:0][31:0]         wb_result;
  cmt_require_t [1:0]       cmt_require;
  logic [ID_W:0]            count;
  logic                     empty;

  int total = 0;
  int bad   = 0;
  int ret_cnt = 0;
  bit mon_en = 1'b0;
  logic [63:0] exp_q [$];
  int exp_tail;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alloc_req      (alloc_req),
    .alloc_reg_need (alloc_reg_need),
    .alloc_reg_addr (alloc_reg_addr),
    .alloc_ready    (alloc_ready),
    .alloc_id       (alloc_id),
    .wb_valid       (wb_valid),
    .wb_id          (wb_id),
    .wb_result      (wb_result),
    .cmt_require    (cmt_require),
    .count          (count),
    .empty          (empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bundle(input logic need, input logic [4:0] addr,
                                         input logic [31:0] res);
    return {26'd0, need, addr, res};
  endfunction

  function automatic logic [4:0] addr_of(input int i);
    return 5'((i % 31) + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_en) begin
      for (int s = 0; s < 2; s++) begin
        if (cmt_require[s] !== '0) begin
          if (exp_q.size() == 0) chk("stream_extra", 64'(cmt_require[s]), 64'd0);
          else begin
            chk("stream_order", 64'(cmt_require[s]), exp_q.pop_front());
            ret_cnt++;
          end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_req = '0; alloc_reg_need = '0; alloc_reg_addr = '0;
    wb_valid = '0; wb_id = '0; wb_result = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;

    // 1: reset
    tick(); tick();
    rst = 0;
    chk("rst_cmt0", 64'(cmt_require[0]), 64'd0);
    chk("rst_cmt1", 64'(cmt_require[1]), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_id0", 64'(alloc_id[0]), 64'd0);
    chk("rst_id1", 64'(alloc_id[1]), 64'd1);

    // 2: out-of-order writeback, in-order pair retire
    alloc_req = 2'b11; alloc_reg_need = 2'b11;
    alloc_reg_addr[0] = 5'd3; alloc_reg_addr[1] = 5'd4;
    tick();
    idle_inputs();
    chk("t2_count", 64'(count), 64'd2);
    wb_valid = 2'b01; wb_id[0] = 4'd1; wb_result[0] = 32'h22;
    tick();
    chk("t2_hold_a", 64'(cmt_require[0]), 64'd0);
    wb_valid = 2'b01; wb_id[0] = 4'd0; wb_result[0] = 32'h11;
    tick();
    idle_inputs();
    chk("t2_hold_b", 64'(cmt_require[0]), 64'd0);
    chk("t2_count_b", 64'(count), 64'd2);
    tick();
    chk("t2_cmt0", 64'(cmt_require[0]), bundle(1'b1, 5'd3, 32'h11));
    chk("t2_cmt1", 64'(cmt_require[1]), bundle(1'b1, 5'd4, 32'h22));
    chk("t2_count_c", 64'(count), 64'd0);
    tick();
    chk("t2_idle_cmt", 64'(cmt_require[0]), 64'd0);

    // 3: fill to full, overflow alloc dropped
    alloc_req = 2'b11; alloc_reg_need = 2'b11;
    for (int p = 0; p < 7; p++) tick();
    chk("t3_count14", 64'(count), 64'd14);
    chk("t3_ready14", 64'(alloc_ready), 64'd1);
    tick();
    chk("t3_count16", 64'(count), 64'd16);
    chk("t3_ready16", 64'(alloc_ready), 64'd0);
    chk("t3_tail16", 64'(alloc_id[0]), 64'd2);
    tick();
    chk("t3_drop_count", 64'(count), 64'd16);
    chk("t3_drop_tail", 64'(alloc_id[0]), 64'd2);
    idle_inputs();
    flush = 1;
    tick();
    flush = 0;
    chk("t3_flush_count", 64'(count), 64'd0);
    chk("t3_flush_tail", 64'(alloc_id[0]), 64'd0);

    // 4: 40-instruction stream in batches of 8, writeback in reverse pairs
    exp_tail = 0;
    mon_en = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int p = 0; p < 4; p++) begin
        int i0;
        i0 = b * 8 + 2 * p;
        alloc_req = 2'b11; alloc_reg_need = 2'b11;
        alloc_reg_addr[0] = addr_of(i0); alloc_reg_addr[1] = addr_of(i0 + 1);
        chk("t4_alloc_id", 64'(alloc_id[0]), 64'(exp_tail));
        exp_q.push_back(bundle(1'b1, addr_of(i0), 32'h1000 + i0));
        exp_q.push_back(bundle(1'b1, addr_of(i0 + 1), 32'h1000 + i0 + 1));
        tick();
        exp_tail = (exp_tail + 2) % DEPTH;
      end
      idle_inputs();
      for (int p = 3; p >= 0; p--) begin
        int i0;
        i0 = b * 8 + 2 * p;
        wb_valid = 2'b11;
        wb_id[0] = 4'((i0 + 1) % DEPTH); wb_result[0] = 32'h1000 + i0 + 1;
        wb_id[1] = 4'(i0 % DEPTH);       wb_result[1] = 32'h1000 + i0;
        tick();
      end
      idle_inputs();
      for (int d = 0; d < 5; d++) tick();
      chk("t4_batch_count", 64'(count), 64'd0);
    end
    mon_en = 1'b0;
    chk("t4_retired", 64'(ret_cnt), 64'd40);
    chk("t4_empty", 64'(empty), 64'd1);

    // 5: reg_need=0 at head retires with its successor in one cycle
    chk("t5_id", 64'(alloc_id[0]), 64'd8);
    alloc_req = 2'b11; alloc_reg_need = 2'b10;
    alloc_reg_addr[0] = 5'd7; alloc_reg_addr[1] = 5'd9;
    tick();
    idle_inputs();
    wb_valid = 2'b11; wb_id[0] = 4'd8; wb_result[0] = 32'h55;
    wb_id[1] = 4'd9; wb_result[1] = 32'h66;
    tick();
    idle_inputs();
    chk("t5_latency", 64'(cmt_require[0]), 64'd0);
    tick();
    chk("t5_cmt0", 64'(cmt_require[0]), bundle(1'b0, 5'd7, 32'h55));
    chk("t5_cmt1", 64'(cmt_require[1]), bundle(1'b1, 5'd9, 32'h66));
    chk("t5_count", 64'(count), 64'd0);

    // 5b: single alloc, both wb ports hit the same id -> port1 wins
    alloc_req = 2'b01; alloc_reg_need = 2'b01; alloc_reg_addr[0] = 5'd12;
    tick();
    idle_inputs();
    wb_valid = 2'b11; wb_id[0] = 4'd10; wb_result[0] = 32'hAA;
    wb_id[1] = 4'd10; wb_result[1] = 32'hBB;
    tick();
    idle_inputs();
    tick();
    chk("t5b_cmt0", 64'(cmt_require[0]), bundle(1'b1, 5'd12, 32'hBB));
    chk("t5b_cmt1", 64'(cmt_require[1]), 64'd0);
    chk("t5b_tail", 64'(alloc_id[0]), 64'd11);

    // 6: flush with pending retire, alloc and wb all in the same cycle
    alloc_req = 2'b11; alloc_reg_need = 2'b11;
    alloc_reg_addr[0] = 5'd1; alloc_reg_addr[1] = 5'd2;
    tick(); tick(); tick();
    idle_inputs();
    chk("t6_count6", 64'(count), 64'd6);
    wb_valid = 2'b11; wb_id[0] = 4'd11; wb_result[0] = 32'h77;
    wb_id[1] = 4'd12; wb_result[1] = 32'h88;
    tick();
    flush = 1; alloc_req = 2'b11;
    wb_valid = 2'b01; wb_id[0] = 4'd13; wb_result[0] = 32'h99;
    tick();
    idle_inputs();
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_cmt0", 64'(cmt_require[0]), 64'd0);
    chk("t6_cmt1", 64'(cmt_require[1]), 64'd0);
    chk("t6_ready", 64'(alloc_ready), 64'd1);
    chk("t6_tail", 64'(alloc_id[0]), 64'd0);
    tick();
    chk("t6_after_count", 64'(count), 64'd0);
    chk("t6_after_cmt", 64'(cmt_require[0]), 64'd0);

    // 7: reset mid-operation behaves like flush
    alloc_req = 2'b11; alloc_reg_need = 2'b11;
    tick();
    idle_inputs();
    chk("t7_count2", 64'(count), 64'd2);
    rst = 1;
    tick();
    rst = 0;
    chk("t7_count", 64'(count), 64'd0);
    chk("t7_empty", 64'(empty), 64'd1);
    chk("t7_tail", 64'(alloc_id[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
